// File: rtl/sram_boot_sequencer.sv
// Boot-time SRAM owner: unpacks host ROM words into timed byte writes, then hands the port to the core.
// Optional BOOT_RELOAD_EN adds host_reload_i to re-enter the load sequence from the done state.
module sram_boot_sequencer #(
  parameter int unsigned       ADDR_W    = 21,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ROM_BYTES = 65536,
  parameter int unsigned       WE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       host_bootdata_i,
  input  logic              host_bootdata_req_i,
  output logic              host_bootdata_ack_o,
  output logic              host_rom_initialised_o,
  output logic              cpu_hold_o,
`ifdef BOOT_RELOAD_EN
  input  logic              host_reload_i,
`endif
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_dout_i,
  input  logic              cpu_we_n_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [7:0]        sram_dout_o,
  output logic              sram_oe_o,
  output logic              sram_we_n_o
);

  localparam int unsigned       WeCntW  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [WeCntW-1:0] WeLast  = WeCntW'(WE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LastCnt = ADDR_W'(ROM_BYTES - 1);

  typedef enum logic [2:0] {StWait, StSetup, StWe, StHold, StDone} state_e;

  state_e              state_q;
  logic [31:0]         word_q;
  logic [1:0]          lane_q;
  logic [ADDR_W-1:0]   byte_cnt_q;
  logic [WeCntW-1:0]   we_cnt_q;
  logic                ack_q;
  logic                init_q;
  logic                hold_q;
  logic [ADDR_W-1:0]   ld_addr_q;
  logic [7:0]          ld_dout_q;
  logic                ld_oe_q;
  logic                ld_we_n_q;

  // Lane 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StWait;
      word_q     <= '0;
      lane_q     <= '0;
      byte_cnt_q <= '0;
      we_cnt_q   <= '0;
      ack_q      <= 1'b0;
      init_q     <= 1'b0;
      hold_q     <= 1'b1;
      ld_addr_q  <= BASE_ADDR;
      ld_dout_q  <= '0;
      ld_oe_q    <= 1'b0;
      ld_we_n_q  <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (host_bootdata_req_i) begin
            word_q    <= host_bootdata_i;
            lane_q    <= 2'd0;
            ack_q     <= 1'b1;
            ld_addr_q <= BASE_ADDR + byte_cnt_q;
            ld_dout_q <= lane_byte(host_bootdata_i, 2'd0);
            ld_oe_q   <= 1'b1;
            ld_we_n_q <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          ld_we_n_q <= 1'b0;
          we_cnt_q  <= '0;
          state_q   <= StWe;
        end
        StWe: begin
          if (we_cnt_q == WeLast) begin
            ld_we_n_q <= 1'b1;
            state_q   <= StHold;
          end else begin
            we_cnt_q <= we_cnt_q + 1'b1;
          end
        end
        StHold: begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
          if (lane_q != 2'd3) begin
            lane_q    <= lane_q + 2'd1;
            ld_addr_q <= BASE_ADDR + byte_cnt_q + 1'b1;
            ld_dout_q <= lane_byte(word_q, lane_q + 2'd1);
            state_q   <= StSetup;
          end else if (byte_cnt_q == LastCnt) begin
            init_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            // Stop driving the data bus while waiting for the next host word.
            ld_oe_q <= 1'b0;
            state_q <= StWait;
          end
        end
        StDone: begin
`ifdef BOOT_RELOAD_EN
          if (host_reload_i) begin
            init_q     <= 1'b0;
            hold_q     <= 1'b1;
            byte_cnt_q <= '0;
            lane_q     <= '0;
            ld_addr_q  <= BASE_ADDR;
            ld_oe_q    <= 1'b0;
            ld_we_n_q  <= 1'b1;
            state_q    <= StWait;
          end
`endif
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign host_bootdata_ack_o    = ack_q;
  assign host_rom_initialised_o = init_q;
  assign cpu_hold_o             = hold_q;

  // The core only reaches the SRAM once loading is complete.
  always_comb begin
    sram_addr_o = ld_addr_q;
    sram_dout_o = ld_dout_q;
    sram_oe_o   = ld_oe_q;
    sram_we_n_o = ld_we_n_q;
    if (state_q == StDone) begin
      sram_addr_o = cpu_addr_i;
      sram_dout_o = cpu_dout_i;
      sram_oe_o   = ~cpu_we_n_i;
      sram_we_n_o = cpu_we_n_i;
    end
  end

endmodule

// File: tb/tb_sram_boot_sequencer.sv
// Directed bench for sram_boot_sequencer with ROM_BYTES=8, WE_CYCLES=2; a negedge monitor logs SRAM writes.
module tb_sram_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] host_bootdata = '0;
  logic        host_req = 1'b0;
  logic        ack, init, hold;
  logic [20:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_we_n = 1'b1;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_oe, sram_we_n;
`ifdef BOOT_RELOAD_EN
  logic        host_reload = 1'b0;
`endif

  always #5 clk = ~clk;

  sram_boot_sequencer #(
    .ADDR_W    (21),
    .BASE_ADDR (21'h0),
    .ROM_BYTES (8),
    .WE_CYCLES (2)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .host_bootdata_i        (host_bootdata),
    .host_bootdata_req_i    (host_req),
    .host_bootdata_ack_o    (ack),
    .host_rom_initialised_o (init),
    .cpu_hold_o             (hold),
`ifdef BOOT_RELOAD_EN
    .host_reload_i          (host_reload),
`endif
    .cpu_addr_i             (cpu_addr),
    .cpu_dout_i             (cpu_dout),
    .cpu_we_n_i             (cpu_we_n),
    .sram_addr_o            (sram_addr),
    .sram_dout_o            (sram_dout),
    .sram_oe_o              (sram_oe),
    .sram_we_n_o            (sram_we_n)
  );

  int errors = 0;
  int checks = 0;

  // Write log built from the SRAM pins while the loader owns them.
  logic [20:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_low  [16];
  int          n_wr = 0;
  int          low_run = 0;
  logic [20:0] run_addr;
  logic [7:0]  run_data;
  int          unstable = 0;
  int          hit1234 = 0;
  int          ack_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      low_run = 0;
    end else begin
      if (ack) ack_cnt++;
      if (!init) begin
        if (sram_addr == 21'h1234) hit1234++;
        if (!sram_we_n) begin
          if (low_run > 0 && (sram_addr != run_addr || sram_dout != run_data)) unstable++;
          run_addr = sram_addr;
          run_data = sram_dout;
          low_run++;
        end else if (low_run > 0) begin
          if (n_wr < 16) begin
            wr_addr[n_wr] = run_addr;
            wr_data[n_wr] = run_data;
            wr_low[n_wr]  = low_run;
          end
          n_wr++;
          low_run = 0;
        end
      end
    end
  end

  typedef struct {
    int          word_idx;
    int          lane;
    logic [20:0] exp_addr;
    logic [7:0]  exp_data;
  } wr_vec_t;

  wr_vec_t     tab [8];
  logic [31:0] words [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 100);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!init && n < 200);
  endtask

  task automatic clear_log();
    n_wr = 0;
    unstable = 0;
    hit1234 = 0;
    ack_cnt = 0;
  endtask

  // Host keeps req high the whole time; only WAIT may capture a word.
  task automatic load_two();
    int n;
    host_bootdata = words[0];
    host_req = 1'b1;
    wait_ack(n);
    chk("ack word0", {31'b0, ack}, 1);
    host_bootdata = words[1];
    wait_ack(n);
    chk("ack word1", {31'b0, ack}, 1);
    chk("ack spacing", n, 17);
    wait_init(n);
    chk("init latency", n, 16);
    repeat (4) @(posedge clk);
    #1 host_req = 1'b0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, " write count"}, n_wr, 8);
    chk({tag, " ack count"}, ack_cnt, 2);
    chk({tag, " addr/data stable while we_n low"}, unstable, 0);
    chk({tag, " core addr untouched"}, hit1234, 0);
    for (int i = 0; i < 8; i++) begin
      if (i < n_wr) begin
        chk($sformatf("%s w%0d.l%0d addr", tag, tab[i].word_idx, tab[i].lane),
            {11'b0, wr_addr[i]}, {11'b0, tab[i].exp_addr});
        chk($sformatf("%s w%0d.l%0d data", tag, tab[i].word_idx, tab[i].lane),
            {24'b0, wr_data[i]}, {24'b0, tab[i].exp_data});
        chk($sformatf("%s w%0d.l%0d we_n low cycles", tag, tab[i].word_idx, tab[i].lane),
            wr_low[i], 2);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ack"}, {31'b0, ack}, 0);
    chk({tag, " init"}, {31'b0, init}, 0);
    chk({tag, " hold"}, {31'b0, hold}, 1);
    chk({tag, " sram_addr"}, {11'b0, sram_addr}, 0);
    chk({tag, " sram_dout"}, {24'b0, sram_dout}, 0);
    chk({tag, " sram_oe"}, {31'b0, sram_oe}, 0);
    chk({tag, " sram_we_n"}, {31'b0, sram_we_n}, 1);
  endtask

  initial begin
    int n;
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01020304;
    tab[0] = '{0, 0, 21'd0, 8'hDE};
    tab[1] = '{0, 1, 21'd1, 8'hAD};
    tab[2] = '{0, 2, 21'd2, 8'hBE};
    tab[3] = '{0, 3, 21'd3, 8'hEF};
    tab[4] = '{1, 0, 21'd4, 8'h01};
    tab[5] = '{1, 1, 21'd5, 8'h02};
    tab[6] = '{1, 2, 21'd6, 8'h03};
    tab[7] = '{1, 3, 21'd7, 8'h04};

    // Core tries to write during the whole load.
    cpu_addr = 21'h1234;
    cpu_dout = 8'h77;
    cpu_we_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    clear_log();

    load_two();
    check_log("load1");
    chk("done init", {31'b0, init}, 1);
    chk("done hold", {31'b0, hold}, 0);

    // Combinational handover to the core.
    cpu_addr = 21'h00010;
    cpu_dout = 8'h55;
    cpu_we_n = 1'b0;
    #1;
    chk("core sram_addr", {11'b0, sram_addr}, 32'h10);
    chk("core sram_dout", {24'b0, sram_dout}, 32'h55);
    chk("core sram_oe", {31'b0, sram_oe}, 1);
    chk("core sram_we_n", {31'b0, sram_we_n}, 0);
    cpu_we_n = 1'b1;
    #1;
    chk("core read sram_oe", {31'b0, sram_oe}, 0);
    chk("core read sram_we_n", {31'b0, sram_we_n}, 1);

`ifdef BOOT_RELOAD_EN
    @(posedge clk); #1 host_reload = 1'b1;
    @(posedge clk); #1 host_reload = 1'b0;
    chk("reload init", {31'b0, init}, 0);
    chk("reload hold", {31'b0, hold}, 1);
    clear_log();
    host_bootdata = 32'hA5A5A5A5;
    host_req = 1'b1;
    wait_ack(n);
    chk("reload ack", {31'b0, ack}, 1);
    host_req = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("reload write count", n_wr, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reload b%0d addr", i), {11'b0, wr_addr[i]}, i);
      chk($sformatf("reload b%0d data", i), {24'b0, wr_data[i]}, 32'hA5);
    end
`endif

    // Restart from a clean load, then reset in the middle of lane 2 of the first word.
    cpu_addr = 21'h1234;
    cpu_we_n = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_log();
    host_bootdata = words[0];
    host_req = 1'b1;
    wait_ack(n);
    chk("midload ack", {31'b0, ack}, 1);
    host_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midload we_n low", {31'b0, sram_we_n}, 0);
    chk("midload addr", {11'b0, sram_addr}, 2);
    chk("midload data", {24'b0, sram_dout}, 32'hBE);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async reset");
    @(posedge clk); #1 rst = 1'b0;
    clear_log();
    load_two();
    check_log("reload after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
